// File: rtl/pt_tx_sched.sv
// PT2262 frame scheduler: FIFO of 24-bit codewords, each sent REPEATS times with a GAP_CYCLES idle gap.
// Optional abort input is enabled by defining PT_TX_SCHED_ABORT_EN.
module pt_tx_sched #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned REPEATS    = 4,
  parameter int unsigned GAP_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [23:0] wr_data,
  output logic        full,
  output logic        overflow,
  output logic        enc_ld,
  output logic [23:0] enc_ad,
  input  logic        enc_done,
  output logic        busy
`ifdef PT_TX_SCHED_ABORT_EN
  ,
  input  logic        abort
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_START, WAIT_DONE, GAP} state_t;

  state_t        state_q, state_d;
  logic [23:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, overflow_q, overflow_d;
  logic [23:0]   cur_word_q, cur_word_d, ad_hold_q, ad_hold_d;
  logic [7:0]    rep_cnt_q, rep_cnt_d;
  logic [15:0]   gap_cnt_q, gap_cnt_d;
  logic [1:0]    wait_cnt_q, wait_cnt_d;
  logic          push, pop, abort_i;

`ifdef PT_TX_SCHED_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cur_word_d = cur_word_q;
    rep_cnt_d  = rep_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    wait_cnt_d = wait_cnt_q;
    pop        = 1'b0;
    enc_ld     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((count_q != '0) && enc_done) begin
          pop        = 1'b1;
          cur_word_d = mem_q[rd_ptr_q];
          rep_cnt_d  = '0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        enc_ld     = 1'b1;
        wait_cnt_d = '0;
        state_d    = WAIT_START;
      end
      WAIT_START: begin
        // Encoder that never drops done gets the load strobe re-issued.
        if (!enc_done) begin
          state_d = WAIT_DONE;
        end else if (wait_cnt_q == 2'd3) begin
          state_d = LOAD;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      WAIT_DONE: begin
        if (enc_done) begin
          gap_cnt_d = 16'(GAP_CYCLES - 1);
          rep_cnt_d = rep_cnt_q + 8'd1;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = (rep_cnt_q < 8'(REPEATS)) ? LOAD : IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_i) begin
      state_d = IDLE;
      pop     = 1'b0;
    end
  end

  always_comb begin
    push       = wr_en && !full_q && !abort_i;
    overflow_d = overflow_q | (wr_en && full_q && !abort_i);
    if (abort_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
    end
    full_d    = (count_d == CW'(DEPTH));
    ad_hold_d = (state_q == LOAD) ? cur_word_q : ad_hold_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      cur_word_q <= '0;
      ad_hold_q  <= '0;
      rep_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      cur_word_q <= cur_word_d;
      ad_hold_q  <= ad_hold_d;
      rep_cnt_q  <= rep_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign enc_ad   = (state_q == LOAD) ? cur_word_q : ad_hold_q;
  assign busy     = (state_q != IDLE);
  assign full     = full_q;
  assign overflow = overflow_q;

endmodule
